// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: picks one completed result
// per cycle from the execution units and drives the registered CDB
// broadcast consumed by the register status table, reservation stations
// and ROB. A flush (branch mispredict) suppresses arbitration that cycle.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_data,
  output logic [$clog2(NUM_REQ)-1:0] cdb_src
);

  localparam int SRC_W = $clog2(NUM_REQ);

  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

  logic              win_found;
  int                win_idx;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;

  // Round-robin search starting at rr_ptr; the modulo wrap is done by
  // subtraction so NUM_REQ need not be a power of two. Flush and reset
  // both suppress the grant.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = 0;
    grant     = '0;
    win_tag   = '0;
    win_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!win_found && (j == cand) && req_valid[j]) begin
          win_found = 1'b1;
          win_idx   = j;
        end
      end
    end
    if (flush || rst) win_found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win_found && (j == win_idx)) begin
        grant[j] = 1'b1;
        win_tag  = req_tag[j*TAG_W +: TAG_W];
        win_data = req_data[j*DATA_W +: DATA_W];
      end
    end
  end

  // Next broadcast state: a winner loads the bus and moves priority to the
  // unit after it; otherwise the bus goes invalid and payload/pointer hold.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (win_found) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = win_tag;
      cdb_data_d  = win_data;
      cdb_src_d   = SRC_W'(win_idx);
      rr_ptr_d    = (win_idx == NUM_REQ - 1) ? '0 : SRC_W'(win_idx + 1);
    end
  end

  // Broadcast and priority registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter with four requesters. Each unit
// presents a fixed tag/data pair; only req_valid, flush and rst change.
module tb_cdb_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 6;
  localparam int DATA_W  = 32;

  logic                      clk;
  logic                      rst;
  logic                      flush;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic [1:0]                cdb_src;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  // Per-unit payloads; unit 0 uses tag 0 since zero is a legal tag.
  logic [TAG_W-1:0]  unit_tag  [NUM_REQ];
  logic [DATA_W-1:0] unit_data [NUM_REQ];

  cdb_arbiter #(
    .NUM_REQ(NUM_REQ),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .req_valid(req_valid),
    .req_tag  (req_tag),
    .req_data (req_data),
    .grant    (grant),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_data (cdb_data),
    .cdb_src  (cdb_src)
  );

  // 10 ns core clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    cmp_cnt++;
    assert (observed === expected)
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic fl);
    req_valid = valid;
    flush     = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkBus(input string name, input logic v, input logic [1:0] src);
    checkOutput({name, "_valid"}, 64'(cdb_valid), 64'(v));
    checkOutput({name, "_src"},   64'(cdb_src),   64'(src));
    checkOutput({name, "_tag"},   64'(cdb_tag),   64'(unit_tag[src]));
    checkOutput({name, "_data"},  64'(cdb_data),  64'(unit_data[src]));
  endtask

  initial begin
    unit_tag[0] = 6'h00; unit_data[0] = 32'h1111_0000;
    unit_tag[1] = 6'h2A; unit_data[1] = 32'hCAFE_0001;
    unit_tag[2] = 6'h15; unit_data[2] = 32'hDEAD_BEEF;
    unit_tag[3] = 6'h3F; unit_data[3] = 32'hA5A5_5A5A;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_tag[i*TAG_W +: TAG_W]    = unit_tag[i];
      req_data[i*DATA_W +: DATA_W] = unit_data[i];
    end

    // Reset state, with requests present to show reset masks the grant.
    rst = 1'b1;
    applyStimulus(4'b1111, 1'b0);
    #1;
    checkOutput("rst_grant", 64'(grant), 64'h0);
    checkOutput("rst_valid", 64'(cdb_valid), 64'h0);
    checkOutput("rst_tag",   64'(cdb_tag),   64'h0);
    checkOutput("rst_data",  64'(cdb_data),  64'h0);
    checkOutput("rst_src",   64'(cdb_src),   64'h0);

    // Release reset between edges (t=7), then a single request from unit 2.
    #5;
    rst = 1'b0;
    applyStimulus(4'b0100, 1'b0);
    checkOutput("single_grant", 64'(grant), 64'b0100);
    tick();
    checkBus("single", 1'b1, 2'd2);

    // Priority now sits at unit 3: with units 3 and 0 asking, 3 wins first.
    applyStimulus(4'b1001, 1'b0);
    checkOutput("wrap_grant3", 64'(grant), 64'b1000);
    tick();
    checkBus("wrap3", 1'b1, 2'd3);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("wrap_grant0", 64'(grant), 64'b0001);
    tick();
    checkBus("wrap0", 1'b1, 2'd0);

    // Flush with unit 1 asking and priority at 1: no grant, bus goes idle.
    applyStimulus(4'b0010, 1'b1);
    checkOutput("flush_grant", 64'(grant), 64'h0);
    tick();
    checkOutput("flush_valid", 64'(cdb_valid), 64'h0);
    checkOutput("flush_src_hold", 64'(cdb_src), 64'd0);
    checkOutput("flush_tag_hold", 64'(cdb_tag), 64'(unit_tag[0]));
    applyStimulus(4'b0010, 1'b0);
    checkOutput("postflush_grant", 64'(grant), 64'b0010);
    tick();
    checkBus("postflush", 1'b1, 2'd1);

    // Idle: bus valid drops, payload holds the unit 1 broadcast.
    applyStimulus(4'b0000, 1'b0);
    checkOutput("idle_grant", 64'(grant), 64'h0);
    tick();
    checkBus("idle", 1'b0, 2'd1);

    // Priority at 2 now; unit 1 alone is still found after wrapping.
    applyStimulus(4'b0010, 1'b0);
    checkOutput("search_grant", 64'(grant), 64'b0010);
    tick();
    checkBus("search", 1'b1, 2'd1);

    // Broadcast live and priority at 2: units 0,2,3 asking picks unit 2.
    applyStimulus(4'b1101, 1'b0);
    checkOutput("prerst_grant", 64'(grant), 64'b0100);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("arst_grant", 64'(grant), 64'h0);
    checkOutput("arst_valid", 64'(cdb_valid), 64'h0);
    checkOutput("arst_tag",   64'(cdb_tag),   64'h0);
    checkOutput("arst_data",  64'(cdb_data),  64'h0);
    checkOutput("arst_src",   64'(cdb_src),   64'h0);
    #1;
    rst = 1'b0;

    // Rotation from reset with everyone asking: 0,1,2,3,0.
    applyStimulus(4'b1111, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("rot_grant%0d", i), 64'(grant), 64'(4'b0001 << (i % 4)));
      tick();
      checkBus($sformatf("rot%0d", i), 1'b1, 2'(i % 4));
    end

    applyStimulus(4'b0000, 1'b0);
    tick();
    checkOutput("end_valid", 64'(cdb_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
